// File: rtl/fxp_to_fp16_norm.sv
// fxp_to_fp16_norm: converts a block-exponent fixed-point accumulator to IEEE FP16,
// normalising one bit per cycle and rounding to nearest-even.
module fxp_to_fp16_norm #(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           exp_in,
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          fp_out,
  output logic                 ovf,
  output logic                 unf
);
  localparam int LZW = $clog2(ACC_WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
  state_t state_q, state_d;
  logic                 sign_q, sign_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [ACC_WIDTH-1:0] mag_q, mag_d;
  logic [4:0]           exp_q, exp_d;
  logic [LZW-1:0]       lz_q, lz_d;
  logic [15:0]          fp_q, fp_d;
  logic [9:0]           mant;
  logic                 guard, sticky, rnd;
  logic [10:0]          mant_r;
  logic signed [15:0]   be, be_r;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = state_q == OUT;
  assign fp_out    = fp_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign mant      = mag_q[ACC_WIDTH-2 -: 10];
  assign guard     = mag_q[ACC_WIDTH-12];
  assign sticky    = |mag_q[ACC_WIDTH-13:0];
  assign rnd       = guard & (sticky | mant[0]);
  assign mant_r    = {1'b0, mant} + 11'(rnd);
  // Unsigned wrap-around arithmetic yields the correct two's-complement result.
  assign be        = 16'(ACC_WIDTH - 1 - FRAC_BITS) + 16'(exp_q) - 16'(lz_q);
  assign be_r      = be + 16'(mant_r[10]);
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    lz_d    = lz_q;
    fp_d    = fp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        sign_d  = acc_in[ACC_WIDTH-1];
        mag_d   = acc_in[ACC_WIDTH-1] ? -acc_in : acc_in;
        exp_d   = exp_in;
        lz_d    = '0;
        state_d = NORM;
      end
      NORM: if (mag_q == '0) begin
        fp_d    = 16'h0000;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = OUT;
      end else if (mag_q[ACC_WIDTH-1]) begin
        state_d = ROUND;
      end else begin
        mag_d = mag_q << 1;
        lz_d  = lz_q + 1'b1;
      end
      ROUND: begin
        ovf_d   = be_r >= 16'sd31;
        unf_d   = be_r <= 16'sd0;
        fp_d    = ovf_d ? {sign_q, 5'h1F, 10'h0} : unf_d ? {sign_q, 15'h0} : {sign_q, be_r[4:0], mant_r[9:0]};
        state_d = OUT;
      end
      default: state_d = out_ready ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      lz_q    <= '0;
      fp_q    <= 16'h0000;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      lz_q    <= lz_d;
      fp_q    <= fp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
endmodule

// File: doc/fxp_to_fp16_norm.md
FXP_TO_FP16_NORM -- requirements
Module: fxp_to_fp16_norm

Interface
REQ-001 The block SHALL have parameter ACC_WIDTH, default 32: accumulator width (>=13).
REQ-002 The block SHALL have parameter FRAC_BITS, default 10: fractional bits of the accumulator.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL provide port clk, input, 1: clock; all state updates on rising edge.
REQ-005 The block SHALL provide port rst, input, 1: synchronous active-high reset.
REQ-006 The block SHALL provide port in_valid, input, 1: exp_in/acc_in valid (MAC done result).
REQ-007 The block SHALL provide port in_ready, output, 1: block can accept; equals (state==IDLE) && !rst.
REQ-008 The block SHALL provide port exp_in, input, 5: shared block exponent from MAC exp_out.
REQ-009 The block SHALL provide port acc_in, input, ACC_WIDTH: two's-complement accumulator from MAC fixed_point_out.
REQ-010 The block SHALL provide port out_valid, output, 1: fp_out/flags valid.
REQ-011 The block SHALL provide port out_ready, input, 1: consumer accepts the result.
REQ-012 The block SHALL provide port fp_out, output, 16: IEEE FP16 result.
REQ-013 The block SHALL provide ports ovf and unf, output, 1 each: overflow-to-inf and flush-to-zero flags, qualified by out_valid.

Function
REQ-014 Input value SHALL be acc_in * 2^(exp_in - 15 - FRAC_BITS).
REQ-015 FSM states SHALL be IDLE, NORM, ROUND and OUT.
REQ-016 In IDLE, on an edge with in_valid && in_ready, the block SHALL capture sign = acc_in MSB and mag = |acc_in| (ACC_WIDTH-bit unsigned; the most-negative value gives 2^(ACC_WIDTH-1)), capture exp_in, clear lz, and enter NORM.
REQ-017 In NORM: if mag==0, go to OUT with fp_out=16'h0000, ovf=0, unf=0; else if mag MSB==1, go to ROUND; else shift mag left by 1 and lz+=1, one bit per cycle.
REQ-018 In ROUND, biased exponent be SHALL be (ACC_WIDTH-1) - lz + exp - FRAC_BITS, computed signed with at least 8 bits.
REQ-019 In ROUND: mantissa = mag[ACC_WIDTH-2 : ACC_WIDTH-11]; guard = mag[ACC_WIDTH-12]; sticky = OR of the bits below guard.
REQ-020 In ROUND, rounding SHALL be round-to-nearest-even; a mantissa carry-out SHALL zero the mantissa and increment be.
REQ-021 After rounding, be>=31 SHALL give fp_out={sign,5'h1F,10'h0} with ovf=1.
REQ-022 After rounding, be<=0 SHALL give fp_out={sign,15'h0} with unf=1; subnormals are not produced.
REQ-023 After rounding, for 0<be<31, fp_out SHALL be {sign, be[4:0], mantissa} with flags 0.
REQ-024 ROUND SHALL always go to OUT on the next edge.
REQ-025 Latency: with acceptance at edge k, out_valid SHALL rise after edge k+lz+2 for a nonzero input and after edge k+1 for a zero input.
REQ-026 In OUT, out_valid=1 and fp_out/ovf/unf SHALL be held stable until an edge with out_ready=1, which returns the FSM to IDLE and clears out_valid.
REQ-027 in_valid SHALL be ignored outside IDLE; there is one transaction in flight and no back-to-back overlap.
REQ-028 out_ready SHALL be ignored when out_valid=0.

Reset
REQ-029 While rst=1 at an edge: state=IDLE, out_valid=0, fp_out=16'h0000, ovf=0, unf=0, lz=0, mag=0.
REQ-030 Reset asserted in NORM, ROUND or OUT SHALL abort the transaction with no output; in_ready=1 on the first cycle after rst deasserts.

Verification
REQ-031 acc_in=32'h00000400, exp_in=15, out_ready=1 -> fp_out=16'h3C00, lz=21, out_valid after edge k+23, flags 0.
REQ-032 acc_in=32'hFFFFFC00, exp_in=15 -> 16'hBC00; acc_in=32'h1, exp_in=15 -> 16'h1400, out_valid after edge k+33.
REQ-033 Rounding: acc_in=2049, exp_in=15 -> 16'h4000 (tie to even); 2051 -> 16'h4002; 4095 -> 16'h4400 (mantissa carry).
REQ-034 Range: acc_in=32'h7FFFFFFF, exp_in=31 -> 16'h7C00, ovf=1; acc_in=1, exp_in=0 -> 16'h0000, unf=1; acc_in=32'hFFFFFFFF, exp_in=0 -> 16'h8000, unf=1.
REQ-035 Zero/backpressure: acc_in=0 -> 16'h0000 after edge k+1; hold out_ready=0 for 5 cycles -> out_valid and fp_out stable and in_ready=0; in_valid pulses during busy are ignored.
REQ-036 Reset mid-NORM (acc_in=1, rst at edge k+10) -> out_valid never rises, in_ready=1 after release, next transaction correct.
